// File: rtl/cpu_pkg.sv
// Shared types for the CPU-side fetch request generator.
package cpu_pkg;

  // Address stream selected by `mode` when a run starts.
  typedef enum logic [1:0] {
    Seq    = 2'd0,
    Stride = 2'd1,
    Loop   = 2'd2,
    Rand   = 2'd3
  } req_mode_e;

  // Run control state.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2,
    StErr   = 2'd3
  } req_state_e;

  // Galois feedback mask for taps 32,22,2,1 (bit t-1 set for tap t).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/cpu_req_gen_lfsr32.sv
// 32-bit right-shifting Galois LFSR used for pseudo-random fetch addresses.
module lfsr32 import cpu_pkg::*; #(
  parameter logic [31:0] RESET_SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  logic [31:0] state_q;
  logic [31:0] state_next;

  // One Galois step: shift right, fold the outgoing bit into the tap positions.
  always_comb begin
    state_next = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : 32'h0);
  end

  // State register; load has priority over advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_SEED;
    end else if (load) begin
      state_q <= seed;
    end else if (advance) begin
      state_q <= state_next;
    end
  end

  assign value = state_q;

endmodule

// File: rtl/cpu_req_gen.sv
// CPU-side instruction fetch request generator for the I-cache front port.
// Optional data checker enabled by defining CPU_REQ_GEN_CHECK_EN.
module cpu_req_gen import cpu_pkg::*; #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        NUM_REQ   = 16,
  parameter int unsigned        STRIDE    = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        LOOP_LEN  = 8,
  parameter int unsigned        TIMEOUT   = 64,
  parameter logic [31:0]        LFSR_SEED = 32'hACE1_0001,
  parameter logic [DATA_W-1:0]  CHECK_XOR = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [1:0]                     mode,
  output logic                           read_en,
  output logic [ADDR_W-1:0]              request_addr,
  input  logic                           hit,
  input  logic [DATA_W-1:0]              requested_data,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout_err,
  output logic [$clog2(NUM_REQ+1)-1:0]   req_count,
  output logic [DATA_W-1:0]              last_data,
  output logic                           data_err
);

  localparam int unsigned CNT_W  = $clog2(NUM_REQ + 1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT);
  localparam int unsigned LOOP_W = $clog2(LOOP_LEN + 1);

  req_state_e          state_q, state_d;
  req_mode_e           mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LOOP_W-1:0]   loop_idx_q, loop_idx_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   last_data_q, last_data_d;
  logic                lfsr_load, lfsr_adv;
  logic [31:0]         lfsr_value;
  logic [ADDR_W-1:0]   rand_addr;
  logic                xfer;
  logic                run_start;

  lfsr32 #(
    .RESET_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (LFSR_SEED),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  // Word-aligned random address; zero-extended when the bus is wider than the LFSR.
  if (ADDR_W <= 32) begin : g_rand_narrow
    assign rand_addr = {lfsr_value[ADDR_W-1:2], 2'b00};
  end else begin : g_rand_wide
    assign rand_addr = {{(ADDR_W - 32){1'b0}}, lfsr_value[31:2], 2'b00};
  end

  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_value;

  assign xfer      = (state_q == StIssue) && hit;
  assign run_start = (state_q != StIssue) && start;

  // Next-state logic: run start, transfer completion, wait counting and timeout.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    loop_idx_d  = loop_idx_q;
    wait_d      = wait_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;

    case (state_q)
      StIssue: begin
        if (hit) begin
          // A hit on the timeout cycle still completes the transfer.
          last_data_d = requested_data;
          cnt_d       = cnt_q + 1'b1;
          wait_d      = '0;
          lfsr_adv    = 1'b1;
          case (mode_q)
            Seq:    addr_d = addr_q + ADDR_W'(4);
            Stride: addr_d = addr_q + ADDR_W'(STRIDE);
            Loop: begin
              if (loop_idx_q == LOOP_W'(LOOP_LEN - 1)) begin
                addr_d     = BASE_ADDR;
                loop_idx_d = '0;
              end else begin
                addr_d     = addr_q + ADDR_W'(4);
                loop_idx_d = loop_idx_q + 1'b1;
              end
            end
            default: addr_d = addr_q;  // Rand addresses come from the LFSR
          endcase
          if (cnt_q == CNT_W'(NUM_REQ - 1)) begin
            state_d = StDone;
          end
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d    = StIssue;
          mode_d     = req_mode_e'(mode);
          addr_d     = BASE_ADDR;
          loop_idx_d = '0;
          wait_d     = '0;
          cnt_d      = '0;
          lfsr_load  = 1'b1;
        end
      end
    endcase
  end

  // Run state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= Seq;
      addr_q      <= BASE_ADDR;
      loop_idx_q  <= '0;
      wait_q      <= '0;
      cnt_q       <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      loop_idx_q  <= loop_idx_d;
      wait_q      <= wait_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
    end
  end

  assign read_en      = (state_q == StIssue);
  assign busy         = (state_q == StIssue);
  assign done         = (state_q == StDone);
  assign timeout_err  = (state_q == StErr);
  assign request_addr = (mode_q == Rand) ? rand_addr : addr_q;
  assign req_count    = cnt_q;
  assign last_data    = last_data_q;

`ifdef CPU_REQ_GEN_CHECK_EN
  localparam int unsigned CMP_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  logic             data_err_q, data_err_d;
  logic [CMP_W-1:0] exp_data, got_data;

  // Expected word is the fetch address XOR a fixed pattern, compared at full width.
  always_comb begin
    exp_data   = CMP_W'(request_addr) ^ CMP_W'(CHECK_XOR);
    got_data   = CMP_W'(requested_data);
    data_err_d = data_err_q;
    if (run_start) begin
      data_err_d = 1'b0;
    end else if (xfer && (got_data != exp_data)) begin
      data_err_d = 1'b1;
    end
  end

  // Sticky mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_err_q <= 1'b0;
    end else begin
      data_err_q <= data_err_d;
    end
  end

  assign data_err = data_err_q;
`else
  logic [DATA_W-1:0] unused_check_xor;
  logic              unused_ctrl;
  assign unused_check_xor = CHECK_XOR;
  assign unused_ctrl      = xfer ^ run_start;
  assign data_err         = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_req_gen.sv
// Self-checking bench for cpu_req_gen: directed scenarios plus randomized runs
// against a closed-form address model.
module tb_cpu_req_gen;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REQ  = 5;
  localparam int unsigned STRIDE   = 16;
  localparam int unsigned LOOP_LEN = 2;
  localparam int unsigned TIMEOUT  = 8;
  localparam logic [31:0] BASE     = 32'h0000_0100;
  localparam logic [31:0] SEED     = 32'hACE1_0001;
  localparam logic [31:0] XORV     = 32'h0000_00FF;
`ifdef CPU_REQ_GEN_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        read_en;
  logic [31:0] request_addr;
  logic        hit;
  logic [31:0] requested_data;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [2:0]  req_count;
  logic [31:0] last_data;
  logic        data_err;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          wt[NUM_REQ];
  logic [31:0] seen_q[$];
  logic [31:0] first_q[$];
  logic [31:0] last_sent;

  cpu_req_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_REQ   (NUM_REQ),
    .STRIDE    (STRIDE),
    .BASE_ADDR (BASE),
    .LOOP_LEN  (LOOP_LEN),
    .TIMEOUT   (TIMEOUT),
    .LFSR_SEED (SEED),
    .CHECK_XOR (XORV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .read_en        (read_en),
    .request_addr   (request_addr),
    .hit            (hit),
    .requested_data (requested_data),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .req_count      (req_count),
    .last_data      (last_data),
    .data_err       (data_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Polynomial x^32+x^22+x^2+x+1, Galois form.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] mask;
    mask = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;
    return (x >> 1) ^ (x[0] ? mask : 32'h0);
  endfunction

  // Address of request i under each mode, computed directly from its index.
  function automatic logic [31:0] model_addr(input int m, input int i);
    logic [31:0] x;
    case (m)
      0: return BASE + 32'(4 * i);
      1: return BASE + 32'(STRIDE * i);
      2: return BASE + 32'(4 * (i % LOOP_LEN));
      default: begin
        x = SEED;
        for (int k = 0; k < i; k++) x = lfsr_next(x);
        return {x[31:2], 2'b00};
      end
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, ".read_en"}, read_en, 0);
    check({tag, ".addr"}, request_addr, BASE);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".timeout_err"}, timeout_err, 0);
    check({tag, ".req_count"}, req_count, 0);
    check({tag, ".last_data"}, last_data, 0);
    check({tag, ".data_err"}, data_err, 0);
  endtask

  // Full run in mode m using wait table wt; request bad_idx gets corrupted data.
  task automatic run(input int m, input int bad_idx);
    logic [31:0] a;
    bit          exp_derr;
    exp_derr = 1'b0;
    seen_q.delete();
    start = 1'b1;
    mode  = 2'(m);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a = model_addr(m, i);
      for (int c = 0; c <= wt[i]; c++) begin
        check("run.read_en", read_en, 1);
        check("run.addr", request_addr, a);
        check("run.busy", busy, 1);
        if (c == 0) begin
          check("run.req_count", req_count, i);
          check("run.data_err", data_err, exp_derr);
          check("run.timeout_err", timeout_err, 0);
          seen_q.push_back(request_addr);
        end
        hit = (c == wt[i]);
        requested_data = hit ? (a ^ XORV ^ 32'(i == bad_idx)) : $urandom;
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom);
        @(posedge clk); #1;
        hit   = 1'b0;
        start = 1'b0;
      end
      if (i == bad_idx) exp_derr = CHECK_ON;
      last_sent = a ^ XORV ^ 32'(i == bad_idx);
    end
    check("end.done", done, 1);
    check("end.read_en", read_en, 0);
    check("end.busy", busy, 0);
    check("end.timeout_err", timeout_err, 0);
    check("end.req_count", req_count, NUM_REQ);
    check("end.last_data", last_data, last_sent);
    check("end.data_err", data_err, exp_derr);
    // A hit outside ISSUE must change nothing.
    hit = 1'b1;
    requested_data = $urandom;
    @(posedge clk); #1;
    hit = 1'b0;
    check("idle_hit.req_count", req_count, NUM_REQ);
    check("idle_hit.last_data", last_data, last_sent);
    check("idle_hit.done", done, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    hit = 1'b0;
    requested_data = '0;
    last_sent = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // SEQ, zero-wait: back-to-back transfers.
    wt = '{0, 0, 0, 0, 0};
    run(0, -1);
    // STRIDE with three wait cycles per hit.
    wt = '{3, 3, 3, 3, 3};
    run(1, -1);
    // LOOP with irregular waits.
    wt = '{1, 0, 2, 0, 1};
    run(2, -1);
    // Hits landing exactly on the timeout cycle still complete.
    wt = '{TIMEOUT - 1, 0, TIMEOUT - 1, 1, 0};
    run(0, -1);

    // Timeout: no hit for TIMEOUT issue cycles.
    start = 1'b1;
    mode  = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      check("to.read_en", read_en, 1);
      check("to.addr", request_addr, BASE);
      @(posedge clk); #1;
    end
    check("to.timeout_err", timeout_err, 1);
    check("to.read_en_low", read_en, 0);
    check("to.busy", busy, 0);
    check("to.done", done, 0);
    hit = 1'b1;
    @(posedge clk); #1;
    hit = 1'b0;
    check("to.sticky", timeout_err, 1);
    check("to.req_count", req_count, 0);
    // Restart clears the error and begins again at BASE.
    wt = '{0, 1, 0, 1, 0};
    run(0, -1);

    // Reset mid-run at request 2.
    start = 1'b1;
    mode  = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("mid.addr", request_addr, model_addr(1, i));
      hit = 1'b1;
      requested_data = model_addr(1, i) ^ XORV;
      @(posedge clk); #1;
      hit = 1'b0;
    end
    check("mid.req_count", req_count, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    wt = '{0, 0, 1, 0, 0};
    run(0, -1);

    // RAND: two runs must produce identical address streams.
    wt = '{0, 2, 0, 1, 0};
    run(3, -1);
    first_q = seen_q;
    wt = '{1, 0, 0, 3, 0};
    run(3, -1);
    for (int i = 0; i < NUM_REQ; i++) begin
      check("rand.repeat", seen_q[i], first_q[i]);
    end

    // Corrupted data on request index 3.
    wt = '{0, 1, 0, 0, 1};
    run(0, 3);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_REQ; i++) wt[i] = $urandom_range(0, TIMEOUT - 1);
      run($urandom_range(0, 3), $urandom_range(0, 1) ? $urandom_range(0, NUM_REQ - 1) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
